matmul_result_writer: RTL and testbench

Drains the result of the systolic matrix multiplier into the result scratchpad. When the multiplier raises its finish flag, this block snapshots the flat C matrix, overflow flags and dimensions. It then writes the valid (N×M) region element by element over a valid/ready write port, and returns the finish-write handshake that releases the multiplier.

---
 rtl/matmul_result_writer.sv | 160 ++++++++++++++++
 tb/tb_matmul_result_writer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_result_writer.sv
// Drains a snapshot of the multiplier's C matrix into the scratchpad, row-major, one beat per accepted handshake.
// Optional MATMUL_WRITER_FLAGS_EN appends one beat carrying the overflow flags after the data region.
module matmul_result_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                                               clk_i,
  input  logic                                               rst_ni,
  input  logic                                               finish_mul_i,
  input  logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)*BUS_WIDTH-1:0] c_matrix_i,
  input  logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0]           flags_i,
  input  logic [1:0]                                         n_dim_i,
  input  logic [1:0]                                         m_dim_i,
  input  logic [ADDR_WIDTH-1:0]                              base_addr_i,
  input  logic                                               wr_ready_i,
  output logic                                               wr_valid_o,
  output logic [ADDR_WIDTH-1:0]                              wr_addr_o,
  output logic [BUS_WIDTH-1:0]                               wr_data_o,
  output logic                                               finish_write_o,
  output logic                                               busy_o
);

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int NELEM   = MAX_DIM * MAX_DIM;
  localparam logic [ADDR_WIDTH-1:0] MAX_DIM_A = ADDR_WIDTH'(MAX_DIM);
  localparam logic [ADDR_WIDTH-1:0] NELEM_A   = ADDR_WIDTH'(NELEM);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  r_q, r_d, c_q, c_d;
  logic [1:0]                  n_q, m_q;
  logic [NELEM*BUS_WIDTH-1:0]  mat_q;
  logic [ADDR_WIDTH-1:0]       base_q;
  logic                        trigger;
  logic                        last_data;
  logic [BUS_WIDTH-1:0]        elem;
  logic [ADDR_WIDTH-1:0]       elem_addr;

  assign trigger   = (state_q == IDLE) && finish_mul_i;
  assign last_data = (r_q == n_q) && (c_q == m_q);

`ifdef MATMUL_WRITER_FLAGS_EN
  logic [NELEM-1:0] flags_q;
  logic             flag_beat_q, flag_beat_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q     <= '0;
      flag_beat_q <= 1'b0;
    end else begin
      flag_beat_q <= flag_beat_d;
      if (trigger) flags_q <= flags_i;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = ^flags_i;
`endif

  // Snapshot is taken only on the IDLE trigger, so it stays frozen for the whole transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mat_q  <= '0;
      n_q    <= '0;
      m_q    <= '0;
      base_q <= '0;
    end else if (trigger) begin
      mat_q  <= c_matrix_i;
      n_q    <= n_dim_i;
      m_q    <= m_dim_i;
      base_q <= base_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
`ifdef MATMUL_WRITER_FLAGS_EN
    flag_beat_d = flag_beat_q;
`endif
    case (state_q)
      IDLE: begin
        if (finish_mul_i) begin
          state_d = WRITE;
          r_d     = '0;
          c_d     = '0;
`ifdef MATMUL_WRITER_FLAGS_EN
          flag_beat_d = 1'b0;
`endif
        end
      end
      WRITE: begin
        if (wr_ready_i) begin
`ifdef MATMUL_WRITER_FLAGS_EN
          if (flag_beat_q) begin
            state_d     = DONE;
            flag_beat_d = 1'b0;
          end else if (last_data) begin
            flag_beat_d = 1'b1;
          end
`else
          if (last_data) begin
            state_d = DONE;
          end
`endif
          else if (c_q == m_q) begin
            c_d = '0;
            r_d = r_q + 2'd1;
          end else begin
            c_d = c_q + 2'd1;
          end
        end
      end
      DONE: begin
        if (!finish_mul_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // C is stored column-major in the flat bus; out-of-range indices read as zero.
  always_comb begin
    elem = '0;
    for (int k = 0; k < NELEM; k++) begin
      if (k == (int'(c_q) * MAX_DIM + int'(r_q))) elem = mat_q[k*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  assign elem_addr = base_q + ADDR_WIDTH'(r_q) * MAX_DIM_A + ADDR_WIDTH'(c_q);

  assign wr_valid_o     = (state_q == WRITE);
  assign finish_write_o = (state_q == DONE);
  assign busy_o         = (state_q != IDLE);

`ifdef MATMUL_WRITER_FLAGS_EN
  assign wr_addr_o = !wr_valid_o ? '0 : (flag_beat_q ? base_q + NELEM_A : elem_addr);
  assign wr_data_o = !wr_valid_o ? '0 : (flag_beat_q ? BUS_WIDTH'(flags_q) : elem);
`else
  logic [ADDR_WIDTH-1:0] unused_nelem;
  assign unused_nelem = NELEM_A;
  assign wr_addr_o = wr_valid_o ? elem_addr : '0;
  assign wr_data_o = wr_valid_o ? elem : '0;
`endif

endmodule

// File: tb/tb_matmul_result_writer.sv
// Scoreboard bench for matmul_result_writer: random and directed transfers against a matrix-level model.
module tb_matmul_result_writer;

  localparam int MD = 2;
  localparam int BW = 16;
  localparam int AW = 8;
  localparam int NE = MD * MD;
`ifdef MATMUL_WRITER_FLAGS_EN
  localparam int FLAG = 1;
`else
  localparam int FLAG = 0;
`endif

  logic              clk;
  logic              rst_n;
  logic              finish_mul;
  logic [NE*BW-1:0]  c_matrix;
  logic [NE-1:0]     flags;
  logic [1:0]        n_dim, m_dim;
  logic [AW-1:0]     base;
  logic              wr_ready;
  logic              wr_valid;
  logic [AW-1:0]     wr_addr;
  logic [BW-1:0]     wr_data;
  logic              finish_write;
  logic              busy;

  matmul_result_writer #(.DATA_WIDTH(8), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .finish_mul_i(finish_mul), .c_matrix_i(c_matrix),
    .flags_i(flags), .n_dim_i(n_dim), .m_dim_i(m_dim), .base_addr_i(base),
    .wr_ready_i(wr_ready), .wr_valid_o(wr_valid), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .finish_write_o(finish_write), .busy_o(busy)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [AW+BW-1:0] exp_q[$];
  logic [BW-1:0] cm [MD][MD];
  logic [NE-1:0] fl;
  int rdy_mode = 0;
  logic rdy_manual = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Ready source: 0 = always ready, 1 = random, 2 = follow rdy_manual
  initial begin
    wr_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: wr_ready = 1'b1;
        1: wr_ready = ($urandom_range(3) != 0);
        default: wr_ready = rdy_manual;
      endcase
    end
  end

  // Monitor: every handshake pops one expected beat; stalled beats must stay put
  initial begin
    logic prev_stall;
    logic [AW+BW-1:0] prev_beat;
    logic [AW+BW-1:0] e;
    prev_stall = 1'b0;
    prev_beat = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("valid_held", {31'd0, wr_valid}, 32'd1);
          if (wr_valid) chk("beat_held", 32'({wr_addr, wr_data}), 32'(prev_beat));
        end
        if (wr_valid && wr_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: got addr 0x%0h data 0x%0h, none expected", wr_addr, wr_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat", 32'({wr_addr, wr_data}), 32'(e));
          end
        end
        prev_stall = wr_valid && !wr_ready;
        prev_beat  = {wr_addr, wr_data};
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic start_txn(input logic [1:0] n, input logic [1:0] m, input logic [AW-1:0] b);
    logic [AW-1:0] a;
    n_dim = n;
    m_dim = m;
    base  = b;
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        c_matrix[(c*MD+r)*BW +: BW] = cm[r][c];
    flags = fl;
    for (int r = 0; r <= int'(n); r++)
      for (int c = 0; c <= int'(m); c++) begin
        a = b + AW'(r*MD + c);
        exp_q.push_back({a, cm[r][c]});
      end
    if (FLAG != 0) begin
      a = b + AW'(NE);
      exp_q.push_back({a, BW'(fl)});
    end
    finish_mul = 1'b1;
  endtask

  task automatic do_txn(input logic [1:0] n, input logic [1:0] m, input logic [AW-1:0] b,
                        input int exp_ticks, input int stall_at, input int stall_len, input int hold);
    int ticks;
    logic done;
    start_txn(n, m, b);
    ticks = 0;
    done = 1'b0;
    while (!done && ticks < 300) begin
      tick();
      ticks++;
      if (ticks == 1) begin
        chk("trigger_valid", {31'd0, wr_valid}, 32'd1);
        chk("trigger_busy", {31'd0, busy}, 32'd1);
      end
      if (stall_len > 0) begin
        if (ticks == stall_at) rdy_manual = 1'b0;
        if (ticks == stall_at + stall_len) rdy_manual = 1'b1;
      end
      if (finish_write) done = 1'b1;
    end
    chk("finish_seen", {31'd0, done}, 32'd1);
    if (exp_ticks >= 0) chk("finish_latency", ticks, exp_ticks);
    chk("beats_left", exp_q.size(), 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("done_finish_held", {31'd0, finish_write}, 32'd1);
      chk("done_no_beat", {31'd0, wr_valid}, 32'd0);
    end
    finish_mul = 1'b0;
    tick();
    chk("release_finish", {31'd0, finish_write}, 32'd0);
    chk("release_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
  endtask

  task automatic load_fixed();
    cm[0][0] = 16'h0011;
    cm[1][0] = 16'h0022;
    cm[0][1] = 16'h0033;
    cm[1][1] = 16'h0044;
    fl = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    finish_mul = 1'b0;
    c_matrix = '0;
    flags = '0;
    n_dim = '0;
    m_dim = '0;
    base = '0;
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, wr_valid}, 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
    chk("rst_finish", {31'd0, finish_write}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    load_fixed();
    do_txn(2'd1, 2'd1, 8'h10, 4 + FLAG + 1, 0, 0, 0);
    do_txn(2'd0, 2'd1, 8'h20, 2 + FLAG + 1, 0, 0, 0);

    rdy_manual = 1'b1;
    rdy_mode = 2;
    do_txn(2'd1, 2'd1, 8'h10, 4 + FLAG + 1 + 3, 2, 3, 0);
    rdy_mode = 0;

    do_txn(2'd1, 2'd1, 8'h30, 4 + FLAG + 1, 0, 0, 5);

    fl = 4'b0101;
    do_txn(2'd1, 2'd1, 8'hFE, 4 + FLAG + 1, 0, 0, 0);

    // Reset in the middle of a transfer, then a clean restart
    load_fixed();
    start_txn(2'd1, 2'd1, 8'h40);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, wr_valid}, 32'd0);
    chk("midrst_addr", 32'(wr_addr), 32'd0);
    chk("midrst_data", 32'(wr_data), 32'd0);
    chk("midrst_finish", {31'd0, finish_write}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_remaining", exp_q.size(), 2 + FLAG);
    finish_mul = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_txn(2'd1, 2'd1, 8'h40, 4 + FLAG + 1, 0, 0, 0);

    rdy_mode = 1;
    for (int t = 0; t < 25; t++) begin
      for (int r = 0; r < MD; r++)
        for (int c = 0; c < MD; c++)
          cm[r][c] = BW'($urandom);
      fl = NE'($urandom);
      do_txn(2'($urandom_range(MD-1)), 2'($urandom_range(MD-1)), AW'($urandom),
             -1, 0, 0, $urandom_range(2));
    end
    rdy_mode = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
